// File: rtl/gray_stream_convert.sv
// -----------------------------------------------------------------------------
// gray_stream_convert
//
// Raster-scans a multi-channel image in a source SRAM and writes a single
// channel image to a destination SRAM at the same coordinates. One read is
// issued per cycle. The read address/valid travel through an RD_LAT-deep
// shift register that tracks the SRAM latency. A single registered compute
// stage follows, so every write lands exactly RD_LAT+1 cycles after its read.
//
// Conversion modes (latched at start):
//   0 luma       g = (77*c0 + 150*c1 + 29*c2 + 128) >> 8
//   1 max        g = max over all channels
//   2 passthru   g = c0
//   3 threshold  all-ones if scaled luma >= thresh, else 0
// If NUM_CH < 3, modes 0 and 3 fall back to passthrough.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start                     begin a frame (sampled only in IDLE)
//   mode, thresh              conversion mode and mode-3 threshold
//   max_x, max_y              last x / y coordinate of the frame (inclusive)
//   x_addr_img, y_addr_img,
//   ren_img, rdat_img         source SRAM read port (channel 0 in the MSBs)
//   x_addr_out, y_addr_out,
//   wen_out, wdat_out         destination SRAM write port
//   busy                      high from the cycle after start to the last write
//   done                      one-cycle pulse after the last write
// -----------------------------------------------------------------------------
module gray_stream_convert #(
  parameter int X_MAX     = 200,
  parameter int Y_MAX     = 200,
  parameter int CH_WIDTH  = 8,
  parameter int NUM_CH    = 3,
  parameter int OUT_WIDTH = 8,
  parameter int RD_LAT    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic [OUT_WIDTH-1:0]       thresh,
  input  logic [$clog2(X_MAX)-1:0]   max_x,
  input  logic [$clog2(Y_MAX)-1:0]   max_y,
  output logic [$clog2(X_MAX):0]     x_addr_img,
  output logic [$clog2(Y_MAX):0]     y_addr_img,
  output logic                       ren_img,
  input  logic [NUM_CH*CH_WIDTH-1:0] rdat_img,
  output logic [$clog2(X_MAX):0]     x_addr_out,
  output logic [$clog2(Y_MAX):0]     y_addr_out,
  output logic                       wen_out,
  output logic [OUT_WIDTH-1:0]       wdat_out,
  output logic                       busy,
  output logic                       done
);

  localparam int XW  = $clog2(X_MAX);
  localparam int YW  = $clog2(Y_MAX);
  localparam int AXW = XW + 1;
  localparam int AYW = YW + 1;
  // Luma intermediate: 256*(2^CH_WIDTH-1)+128 always fits in CH_WIDTH+9 bits.
  localparam int LW  = CH_WIDTH + 9;
  localparam bit HAS_LUMA = (NUM_CH >= 3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Frame configuration, captured when a frame starts.
  logic [1:0]           mode_q;
  logic [OUT_WIDTH-1:0] thresh_q;
  logic [XW-1:0]        max_x_q;
  logic [YW-1:0]        max_y_q;

  // Raster counter.
  logic [AXW-1:0] x_q, x_d;
  logic [AYW-1:0] y_q, y_d;

  logic issue;       // a read is issued this cycle
  logic issue_last;  // the current raster position is the last pixel
  logic x_at_end;

  // Output register stage.
  logic                 wen_q;
  logic                 wlast_q;
  logic [AXW-1:0]       wx_q;
  logic [AYW-1:0]       wy_q;
  logic [OUT_WIDTH-1:0] wdat_q;
  logic [OUT_WIDTH-1:0] wdat_d;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      mode_q   <= '0;
      thresh_q <= '0;
      max_x_q  <= '0;
      max_y_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      if (state_q == IDLE && start) begin
        mode_q   <= mode;
        thresh_q <= thresh;
        max_x_q  <= max_x;
        max_y_q  <= max_y;
      end
    end
  end

  assign x_at_end   = (x_q == {1'b0, max_x_q});
  assign issue_last = x_at_end && (y_q == {1'b0, max_y_q});

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = '0;
          y_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        issue = 1'b1;
        if (x_at_end) begin
          x_d = '0;
          y_d = y_q + AYW'(1);
        end else begin
          x_d = x_q + AXW'(1);
        end
        if (issue_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The last pixel's write is on the port this cycle.
        if (wen_q && wlast_q) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ren_img    = issue;
  assign x_addr_img = issue ? x_q : '0;
  assign y_addr_img = issue ? y_q : '0;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == FIN);

  // ---------------------------------------------------------------------------
  // Read-latency shift register: stage RD_LAT-1 lines up with valid rdat_img.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_rd
    logic           v_q;
    logic           last_q;
    logic [AXW-1:0] sx_q;
    logic [AYW-1:0] sy_q;
    logic           v_in;
    logic           last_in;
    logic [AXW-1:0] sx_in;
    logic [AYW-1:0] sy_in;

    if (gi == 0) begin : g_src
      assign v_in    = issue;
      assign last_in = issue_last;
      assign sx_in   = x_q;
      assign sy_in   = y_q;
    end else begin : g_src
      assign v_in    = g_rd[gi-1].v_q;
      assign last_in = g_rd[gi-1].last_q;
      assign sx_in   = g_rd[gi-1].sx_q;
      assign sy_in   = g_rd[gi-1].sy_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q    <= 1'b0;
        last_q <= 1'b0;
        sx_q   <= '0;
        sy_q   <= '0;
      end else begin
        v_q    <= v_in;
        last_q <= v_in && last_in;
        sx_q   <= sx_in;
        sy_q   <= sy_in;
      end
    end
  end

  logic           rd_v;
  logic           rd_last;
  logic [AXW-1:0] rd_x;
  logic [AYW-1:0] rd_y;

  assign rd_v    = g_rd[RD_LAT-1].v_q;
  assign rd_last = g_rd[RD_LAT-1].last_q;
  assign rd_x    = g_rd[RD_LAT-1].sx_q;
  assign rd_y    = g_rd[RD_LAT-1].sy_q;

  // ---------------------------------------------------------------------------
  // Pixel conversion
  // ---------------------------------------------------------------------------
  logic [CH_WIDTH-1:0] ch [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    // Channel 0 sits in the most significant slice.
    assign ch[gi] = rdat_img[(NUM_CH-1-gi)*CH_WIDTH +: CH_WIDTH];
  end

  logic [CH_WIDTH-1:0] ch_max;

  always_comb begin
    ch_max = ch[0];
    for (int i = 1; i < NUM_CH; i++) begin
      if (ch[i] > ch_max) begin
        ch_max = ch[i];
      end
    end
  end

  logic [CH_WIDTH-1:0] luma;

  if (HAS_LUMA) begin : g_luma
    logic [LW-1:0] luma_sum;
    assign luma_sum = LW'(ch[0]) * LW'(77)
                    + LW'(ch[1]) * LW'(150)
                    + LW'(ch[2]) * LW'(29)
                    + LW'(128);
    assign luma = CH_WIDTH'(luma_sum >> 8);
  end else begin : g_luma
    assign luma = ch[0];
  end

  logic [CH_WIDTH-1:0]  g_sel;
  logic [OUT_WIDTH-1:0] g_scaled;
  logic                 thr_en;

  always_comb begin
    g_sel = ch[0];
    case (mode_q)
      2'd0:    g_sel = luma;
      2'd1:    g_sel = ch_max;
      2'd2:    g_sel = ch[0];
      default: g_sel = luma;
    endcase
  end

  if (CH_WIDTH >= OUT_WIDTH) begin : g_scale
    assign g_scaled = OUT_WIDTH'(g_sel >> (CH_WIDTH - OUT_WIDTH));
  end else begin : g_scale
    assign g_scaled = {g_sel, {(OUT_WIDTH-CH_WIDTH){1'b0}}};
  end

  // Without three channels there is no luma, so thresholding is disabled too.
  assign thr_en = (mode_q == 2'd3) && HAS_LUMA;

  always_comb begin
    wdat_d = g_scaled;
    if (thr_en) begin
      wdat_d = (g_scaled >= thresh_q) ? {OUT_WIDTH{1'b1}} : {OUT_WIDTH{1'b0}};
    end
  end

  // ---------------------------------------------------------------------------
  // Registered compute stage drives the destination write port.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q   <= 1'b0;
      wlast_q <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
      wdat_q  <= '0;
    end else begin
      wen_q   <= rd_v;
      wlast_q <= rd_v && rd_last;
      if (rd_v) begin
        wx_q   <= rd_x;
        wy_q   <= rd_y;
        wdat_q <= wdat_d;
      end else begin
        wx_q   <= '0;
        wy_q   <= '0;
        wdat_q <= '0;
      end
    end
  end

  assign wen_out    = wen_q;
  assign x_addr_out = wx_q;
  assign y_addr_out = wy_q;
  assign wdat_out   = wdat_q;

endmodule

// File: tb/tb_gray_stream_convert.sv
// -----------------------------------------------------------------------------
// Testbench for gray_stream_convert.
// Two instances share stimulus: A (8-bit channels, RD_LAT=1) and
// B (10-bit channels, RD_LAT=3). Both use 8-bit output. The image holds
// 10-bit channel values; A sees the top 8 bits of each, B sees all 10.
// Every cycle of a frame is checked against a closed-form timeline:
// reads at k=1..N, writes at k=L+2..L+1+N, busy through the last write,
// done at k=L+2+N. k counts cycles after the start sample edge.
// -----------------------------------------------------------------------------
module tb_gray_stream_convert;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [7:0] thresh;
  logic [7:0] max_x;
  logic [7:0] max_y;

  logic [8:0]  xa_i, ya_i, xa_o, ya_o;
  logic        ren_a, wen_a, busy_a, done_a;
  logic [23:0] rdat_a;
  logic [7:0]  wd_a;

  logic [8:0]  xb_i, yb_i, xb_o, yb_o;
  logic        ren_b, wen_b, busy_b, done_b;
  logic [29:0] rdat_b;
  logic [29:0] rb_pipe [3];
  logic [7:0]  wd_b;

  int img [3][16][16];
  int wr_a[$];
  int wr_b[$];
  int vectors;
  int miscompares;

  always #5 clk = ~clk;

  gray_stream_convert #(
    .X_MAX(200), .Y_MAX(200), .CH_WIDTH(8), .NUM_CH(3), .OUT_WIDTH(8), .RD_LAT(LAT_A)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .thresh(thresh),
    .max_x(max_x), .max_y(max_y),
    .x_addr_img(xa_i), .y_addr_img(ya_i), .ren_img(ren_a), .rdat_img(rdat_a),
    .x_addr_out(xa_o), .y_addr_out(ya_o), .wen_out(wen_a), .wdat_out(wd_a),
    .busy(busy_a), .done(done_a)
  );

  gray_stream_convert #(
    .X_MAX(200), .Y_MAX(200), .CH_WIDTH(10), .NUM_CH(3), .OUT_WIDTH(8), .RD_LAT(LAT_B)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .thresh(thresh),
    .max_x(max_x), .max_y(max_y),
    .x_addr_img(xb_i), .y_addr_img(yb_i), .ren_img(ren_b), .rdat_img(rdat_b),
    .x_addr_out(xb_o), .y_addr_out(yb_o), .wen_out(wen_b), .wdat_out(wd_b),
    .busy(busy_b), .done(done_b)
  );

  function automatic logic [23:0] word_a(int x, int y);
    return {8'(img[0][y][x] >> 2), 8'(img[1][y][x] >> 2), 8'(img[2][y][x] >> 2)};
  endfunction

  function automatic logic [29:0] word_b(int x, int y);
    return {10'(img[0][y][x]), 10'(img[1][y][x]), 10'(img[2][y][x])};
  endfunction

  // Source SRAM models; data is garbage whenever no read was issued.
  always @(posedge clk) begin
    if (ren_a && xa_i < 16 && ya_i < 16) rdat_a <= word_a(int'(xa_i), int'(ya_i));
    else                                 rdat_a <= 24'($urandom);
  end

  always @(posedge clk) begin
    if (ren_b && xb_i < 16 && yb_i < 16) rb_pipe[0] <= word_b(int'(xb_i), int'(yb_i));
    else                                 rb_pipe[0] <= 30'($urandom);
    rb_pipe[1] <= rb_pipe[0];
    rb_pipe[2] <= rb_pipe[1];
  end

  assign rdat_b = rb_pipe[2];

  // Reference conversion of pixel (x,y) for a converter with cw-bit channels.
  function automatic int ref_pix(int x, int y, int cw, int md, int th);
    int sh, c0, c1, c2, luma, mx, g, s;
    sh = (cw == 8) ? 2 : 0;
    c0 = img[0][y][x] >> sh;
    c1 = img[1][y][x] >> sh;
    c2 = img[2][y][x] >> sh;
    luma = (77 * c0 + 150 * c1 + 29 * c2 + 128) / 256;
    mx = c0;
    if (c1 > mx) mx = c1;
    if (c2 > mx) mx = c2;
    case (md)
      1:       g = mx;
      2:       g = c0;
      default: g = luma;
    endcase
    s = (cw >= 8) ? (g >> (cw - 8)) : (g << (8 - cw));
    if (md == 3) s = (s >= th) ? 255 : 0;
    return s;
  endfunction

  // Address/data fields only matter while their enable is high.
  function automatic logic [47:0] pack(logic ren, logic [8:0] xi, logic [8:0] yi,
                                       logic wen, logic [8:0] xo, logic [8:0] yo,
                                       logic [7:0] wd, logic bsy, logic dn);
    return {ren, ren ? xi : 9'd0, ren ? yi : 9'd0,
            wen, wen ? xo : 9'd0, wen ? yo : 9'd0, wen ? wd : 8'd0, bsy, dn};
  endfunction

  function automatic logic [47:0] expect_vec(int k, int n, int mx, int lat, int cw,
                                             int md, int th);
    logic r, w, b, d;
    int p, q;
    r = (k >= 1) && (k <= n);
    p = r ? k - 1 : 0;
    w = (k >= lat + 2) && (k <= lat + 1 + n);
    q = w ? k - lat - 2 : 0;
    b = (k >= 1) && (k <= lat + 1 + n);
    d = (k == lat + 2 + n);
    return pack(r, 9'(p % (mx + 1)), 9'(p / (mx + 1)),
                w, 9'(q % (mx + 1)), 9'(q / (mx + 1)),
                8'(ref_pix(q % (mx + 1), q / (mx + 1), cw, md, th)), b, d);
  endfunction

  task automatic fill_random();
    for (int c = 0; c < 3; c++)
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++)
          img[c][y][x] = int'($urandom_range(0, 1023));
  endtask

  task automatic set_pix(int x, int y, int c0, int c1, int c2);
    img[0][y][x] = c0;
    img[1][y][x] = c1;
    img[2][y][x] = c2;
  endtask

  // Runs one frame and checks both instances every cycle. With perturb set,
  // start and the configuration inputs are disturbed mid-frame.
  task automatic run_frame(string tag, int md, int th, int mx, int my, bit perturb);
    int n;
    logic [47:0] oa, ob, ea, eb;
    n = (mx + 1) * (my + 1);
    wr_a.delete();
    wr_b.delete();
    @(negedge clk);
    mode = 2'(md); thresh = 8'(th); max_x = 8'(mx); max_y = 8'(my); start = 1'b1;
    for (int k = 1; k <= n + LAT_B + 5; k++) begin
      @(negedge clk);
      oa = pack(ren_a, xa_i, ya_i, wen_a, xa_o, ya_o, wd_a, busy_a, done_a);
      ob = pack(ren_b, xb_i, yb_i, wen_b, xb_o, yb_o, wd_b, busy_b, done_b);
      ea = expect_vec(k, n, mx, LAT_A, 8, md, th);
      eb = expect_vec(k, n, mx, LAT_B, 10, md, th);
      vectors += 2;
      if (oa !== ea) begin
        miscompares++;
        $display("FAIL %s dut=A k=%0d got=%h want=%h", tag, k, oa, ea);
      end
      if (ob !== eb) begin
        miscompares++;
        $display("FAIL %s dut=B k=%0d got=%h want=%h", tag, k, ob, eb);
      end
      if (wen_a) wr_a.push_back(int'(wd_a));
      if (wen_b) wr_b.push_back(int'(wd_b));
      $display("%s k=%0d A ren=%0b wen=%0b wd=%0d | B ren=%0b wen=%0b wd=%0d",
               tag, k, ren_a, wen_a, wd_a, ren_b, wen_b, wd_b);
      start = 1'b0;
      if (perturb && k == 2) begin
        start  = 1'b1;
        mode   = 2'($urandom);
        thresh = 8'($urandom);
        max_x  = 8'($urandom_range(0, 7));
        max_y  = 8'($urandom_range(0, 7));
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [95:0] raw;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    raw = {ren_a, xa_i, ya_i, wen_a, xa_o, ya_o, wd_a, busy_a, done_a,
           ren_b, xb_i, yb_i, wen_b, xb_o, yb_o, wd_b, busy_b, done_b};
    vectors++;
    if (raw !== 96'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h want=0", raw);
    end
    $display("reset outputs=%h", raw);
    rst = 1'b0;
  endtask

  task automatic test_luma_2x2();
    int want [4];
    want = '{77, 149, 29, 255};
    set_pix(0, 0, 1023, 0, 0);
    set_pix(1, 0, 0, 1023, 0);
    set_pix(0, 1, 0, 0, 1023);
    set_pix(1, 1, 1023, 1023, 1023);
    run_frame("luma2x2", 0, 0, 1, 1, 1'b0);
    vectors++;
    if (wr_a.size() != 4) begin
      miscompares++;
      $display("FAIL luma2x2_count got=%0d want=4", wr_a.size());
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (wr_a[i] != want[i]) begin
        miscompares++;
        $display("FAIL luma2x2_pix%0d got=%0d want=%0d", i, wr_a[i], want[i]);
      end
    end
  endtask

  task automatic test_threshold();
    int want [4];
    want = '{0, 255, 0, 255};
    run_frame("thresh", 3, 100, 1, 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      vectors += 2;
      if (wr_a[i] != want[i]) begin
        miscompares++;
        $display("FAIL thresh_A_pix%0d got=%0d want=%0d", i, wr_a[i], want[i]);
      end
      if (wr_b[i] != want[i]) begin
        miscompares++;
        $display("FAIL thresh_B_pix%0d got=%0d want=%0d", i, wr_b[i], want[i]);
      end
    end
  endtask

  // Also the 1x1 frame: one read, one write, one done pulse.
  task automatic test_max_1x1();
    set_pix(0, 0, 40, 800, 120);
    run_frame("max1x1", 1, 0, 0, 0, 1'b0);
    vectors += 2;
    if (wr_a.size() != 1 || wr_a[0] != 200) begin
      miscompares++;
      $display("FAIL max1x1_A got=%0d writes, first=%0d want=1 writes, 200",
               wr_a.size(), wr_a[0]);
    end
    if (wr_b.size() != 1 || wr_b[0] != 200) begin
      miscompares++;
      $display("FAIL max1x1_B got=%0d writes, first=%0d want=1 writes, 200",
               wr_b.size(), wr_b[0]);
    end
  endtask

  task automatic test_lat3_3x2();
    fill_random();
    run_frame("lat3_3x2", 0, 0, 2, 1, 1'b0);
    vectors++;
    if (wr_b.size() != 6) begin
      miscompares++;
      $display("FAIL lat3_count got=%0d want=6", wr_b.size());
    end
  endtask

  task automatic test_wide_passthrough();
    fill_random();
    img[0][0][0] = 10'h3FF;
    img[0][0][1] = 10'h200;
    run_frame("wide_pass", 2, 0, 1, 0, 1'b0);
    vectors += 2;
    if (wr_b[0] != 8'hFF) begin
      miscompares++;
      $display("FAIL wide_pass_3ff got=%h want=ff", wr_b[0]);
    end
    if (wr_b[1] != 8'h80) begin
      miscompares++;
      $display("FAIL wide_pass_200 got=%h want=80", wr_b[1]);
    end
  endtask

  task automatic test_start_ignored();
    fill_random();
    run_frame("restart", int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 3, 3, 1'b1);
    vectors += 2;
    if (wr_a.size() != 16) begin
      miscompares++;
      $display("FAIL restart_A_count got=%0d want=16", wr_a.size());
    end
    if (wr_b.size() != 16) begin
      miscompares++;
      $display("FAIL restart_B_count got=%0d want=16", wr_b.size());
    end
  endtask

  task automatic test_reset_mid_run();
    logic [47:0] oa, ob, ea, eb;
    logic [95:0] raw;
    fill_random();
    @(negedge clk);
    mode = 2'd0; thresh = 8'd0; max_x = 8'd3; max_y = 8'd3; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      oa = pack(ren_a, xa_i, ya_i, wen_a, xa_o, ya_o, wd_a, busy_a, done_a);
      ob = pack(ren_b, xb_i, yb_i, wen_b, xb_o, yb_o, wd_b, busy_b, done_b);
      ea = expect_vec(k, 16, 3, LAT_A, 8, 0, 0);
      eb = expect_vec(k, 16, 3, LAT_B, 10, 0, 0);
      vectors += 2;
      if (oa !== ea) begin
        miscompares++;
        $display("FAIL abort_pre dut=A k=%0d got=%h want=%h", k, oa, ea);
      end
      if (ob !== eb) begin
        miscompares++;
        $display("FAIL abort_pre dut=B k=%0d got=%h want=%h", k, ob, eb);
      end
    end
    rst = 1'b1;
    #1;
    raw = {ren_a, xa_i, ya_i, wen_a, xa_o, ya_o, wd_a, busy_a, done_a,
           ren_b, xb_i, yb_i, wen_b, xb_o, yb_o, wd_b, busy_b, done_b};
    vectors++;
    if (raw !== 96'd0) begin
      miscompares++;
      $display("FAIL abort_outputs got=%h want=0", raw);
    end
    $display("abort outputs=%h", raw);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      oa = pack(ren_a, xa_i, ya_i, wen_a, xa_o, ya_o, wd_a, busy_a, done_a);
      ob = pack(ren_b, xb_i, yb_i, wen_b, xb_o, yb_o, wd_b, busy_b, done_b);
      vectors++;
      if (oa !== 48'd0 || ob !== 48'd0) begin
        miscompares++;
        $display("FAIL abort_quiet k=%0d got A=%h B=%h want 0", k, oa, ob);
      end
    end
    run_frame("after_abort", 0, 0, 3, 3, 1'b0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      fill_random();
      run_frame($sformatf("rand%0d", f), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 4)), 1'b0);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    start = 1'b0;
    mode = 2'd0;
    thresh = 8'd0;
    max_x = 8'd0;
    max_y = 8'd0;
    for (int c = 0; c < 3; c++)
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++)
          img[c][y][x] = 0;

    test_reset();
    test_luma_2x2();
    test_threshold();
    test_max_1x1();
    test_lat3_3x2();
    test_wide_passthrough();
    test_start_ignored();
    test_reset_mid_run();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gray_stream_convert.md
Name: gray_stream_convert

Overview:
- Parametrised successor to the fixed 24-bit colour-to-BW converter.
- Raster-scans an image held in source SRAM and issues one read per cycle, tolerating a configurable SRAM read latency.
- Converts each multi-channel pixel to a single channel using a run-time selected mode: luma, max, passthrough or binary threshold. Writes the result to the destination SRAM at the same coordinates.
- Sits between the image SRAM and the grayscale buffer that feeds the FAST corner stage. Contains its own raster counter, so no external pixel_pos is needed.

Parameters:
- X_MAX, 200: maximum supported image width.
- Y_MAX, 200: maximum supported image height.
- CH_WIDTH, 8: bits per input channel.
- NUM_CH, 3: channels per input pixel. Channel 0 occupies the MSBs of rdat_img.
- OUT_WIDTH, 8: bits per output pixel.
- RD_LAT, 1: source SRAM read latency in cycles, ren_img to valid rdat_img. Must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin a frame. Sampled only in IDLE.
- mode  in  2  0 luma, 1 max, 2 channel-0 passthrough, 3 luma threshold
- thresh  in  OUT_WIDTH  threshold used by mode 3
- max_x  in  $clog2(X_MAX)  last x coordinate, inclusive
- max_y  in  $clog2(Y_MAX)  last y coordinate, inclusive
- x_addr_img  out  $clog2(X_MAX)+1  source read x
- y_addr_img  out  $clog2(Y_MAX)+1  source read y
- ren_img  out  1  source read enable
- rdat_img  in  NUM_CH*CH_WIDTH  source read data
- x_addr_out  out  $clog2(X_MAX)+1  destination write x
- y_addr_out  out  $clog2(Y_MAX)+1  destination write y
- wen_out  out  1  destination write enable
- wdat_out  out  OUT_WIDTH  destination write data
- busy  out  1  high from the cycle after start through the final write
- done  out  1  one-cycle pulse after the final write

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, and the pipeline valid bits are cleared. Reset asserted mid-frame aborts the frame at once; no further reads or writes occur and no done pulse is produced.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE: when start=1, latch mode, thresh, max_x and max_y, clear x/y to 0, and go to RUN. start is ignored in every other state.
  - RUN: each cycle, ren_img=1 with the address equal to the current x/y. Increment x; when x==max_x, wrap x to 0 and increment y. When the issued address is (max_x, max_y), go to DRAIN the next cycle.
  - DRAIN: ren_img=0. Stay until the last pixel's write has been issued.
  - FIN: done=1 for exactly one cycle, then return to IDLE.
- Pipeline:
  - Issue address and valid travel through an RD_LAT-deep shift register alongside the read.
  - One registered compute stage follows the read.
  - wen_out asserts exactly RD_LAT+1 cycles after the matching ren_img, with that pixel's address.
  - Writes arrive in raster order, one per cycle, with no gaps.
  - Frame length N=(max_x+1)*(max_y+1). The first write occurs RD_LAT+2 cycles after start; done follows one cycle after the last write.
- Arithmetic (channels taken from ch0/1/2 = R/G/B):
  - Mode 0: g = (77*ch0 + 150*ch1 + 29*ch2 + 128) >> 8. The intermediate is CH_WIDTH+9 bits wide and the result never exceeds 2^CH_WIDTH-1.
  - Mode 1: g = max over all NUM_CH channels.
  - Mode 2: g = ch0.
  - Mode 3: compute g as in mode 0 and scale it. Output all-ones if scaled g ≥ thresh, else 0.
  - If NUM_CH<3, modes 0 and 3 behave as mode 2.
- Width scaling: when CH_WIDTH ≥ OUT_WIDTH, take the top OUT_WIDTH bits of g. Otherwise left-shift g and zero-fill the low bits.
- max_x=0 and/or max_y=0 are legal; a 1x1 frame produces exactly one write.
- Inputs that change mid-frame are ignored because their values were latched at start.

Test Plan:
- 2x2 frame, mode 0, RD_LAT=1, pixels (255,0,0), (0,255,0), (0,0,255), (255,255,255) → writes 77, 149, 29, 255 at (0,0), (1,0), (0,1), (1,1). Each wen_out falls 2 cycles after its ren_img; done falls 1 cycle after the last write.
- Same pixels with mode 3 and thresh=100 → writes 0, 255, 0, 255. With mode 1 and pixel (10,200,30) → writes 200.
- RD_LAT=3 with a 3x2 frame → exactly 6 consecutive writes, each 4 cycles after its read; busy is high throughout and the addresses are in raster order.
- 1x1 frame (max_x=0, max_y=0) → one read, one write, one done pulse. start pulsed again during RUN of a larger frame → ignored, and the write count equals N.
- rst asserted mid-RUN of a 4x4 frame → all outputs 0 in that cycle; no writes or done afterwards. A fresh start then completes a full frame.
- CH_WIDTH=10, OUT_WIDTH=8, mode 2, ch0=10'h3FF → writes 8'hFF. With ch0=10'h200 → writes 8'h80.
